eth_tx_arb: RTL



---
 rtl/eth_tx_arb.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/eth_tx_arb.sv
// Round-robin arbiter sharing one eth_tx application interface between REQ_N packet sources.
// One requester owns the transmit path per packet; its beats pass through combinationally.
module eth_tx_arb #(
    parameter int unsigned REQ_N          = 2,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned KEEP_W         = DATA_W / 8,
    parameter int unsigned LEN_W          = $clog2(KEEP_W + 1),
    parameter int unsigned PKT_LEN_W      = 16,
    parameter int unsigned UDP_CS_W       = 16,
    parameter int unsigned APP_LAST_LEN_W = $clog2(8 + KEEP_W + 1),
    localparam int unsigned REQ_W         = (REQ_N > 2) ? $clog2(REQ_N) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [REQ_N-1:0]                    req_early_v_i,
    output logic [REQ_N-1:0]                    req_ready_v_o,
    input  logic [REQ_N*PKT_LEN_W-1:0]          req_pkt_len_i,
    input  logic [REQ_N*UDP_CS_W-1:0]           req_cs_i,
    input  logic [REQ_N*DATA_W-1:0]             req_data_i,
    input  logic [REQ_N*LEN_W-1:0]              req_len_i,
    input  logic [REQ_N-1:0]                    req_last_i,
    input  logic [REQ_N-1:0]                    req_cancel_i,
    input  logic [REQ_N-1:0]                    req_last_block_next_i,
    input  logic [REQ_N*APP_LAST_LEN_W-1:0]     req_last_block_next_len_i,
    output logic                                tx_early_v_o,
    output logic                                tx_cancel_o,
    output logic                                tx_last_o,
    output logic                                tx_last_block_next_o,
    output logic [PKT_LEN_W-1:0]                tx_pkt_len_o,
    output logic [UDP_CS_W-1:0]                 tx_cs_o,
    output logic [DATA_W-1:0]                   tx_data_o,
    output logic [LEN_W-1:0]                    tx_len_o,
    output logic [APP_LAST_LEN_W-1:0]           tx_last_block_next_len_o,
    input  logic                                tx_ready_v_i,
    output logic                                busy_o,
    output logic [REQ_W-1:0]                    grant_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t                 state;
    logic [REQ_W-1:0]       grant;
    logic [REQ_W-1:0]       ptr;
    logic [PKT_LEN_W-1:0]   pkt_len_q;

    logic                   pick_found;
    logic [REQ_W-1:0]       pick_idx;
    logic [PKT_LEN_W-1:0]   pick_len;
    int unsigned            scan;

    logic                   g_early;
    logic                   g_last;
    logic                   g_cancel;
    logic                   g_lbn;
    logic [DATA_W-1:0]      g_data;
    logic [LEN_W-1:0]       g_len;
    logic [UDP_CS_W-1:0]    g_cs;
    logic [APP_LAST_LEN_W-1:0] g_lbn_len;

    function automatic logic [REQ_W-1:0] inc_wrap(input logic [REQ_W-1:0] v);
        return (v == REQ_W'(REQ_N - 1)) ? '0 : v + REQ_W'(1);
    endfunction

    // First requesting index at or after ptr, wrapping at REQ_N (works for non-power-of-2 counts)
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = 0;
        for (int unsigned i = 0; i < REQ_N; i++) begin
            scan = 32'(ptr) + i;
            if (scan >= REQ_N) begin
                scan = scan - REQ_N;
            end
            if (!pick_found && req_early_v_i[REQ_W'(scan)]) begin
                pick_found = 1'b1;
                pick_idx   = REQ_W'(scan);
            end
        end
    end

    always_comb begin
        pick_len = '0;
        for (int unsigned r = 0; r < REQ_N; r++) begin
            if (pick_idx == REQ_W'(r)) begin
                pick_len = req_pkt_len_i[r*PKT_LEN_W +: PKT_LEN_W];
            end
        end
    end

    // Slice of the current owner; everyone else is ignored
    always_comb begin
        g_early   = 1'b0;
        g_last    = 1'b0;
        g_cancel  = 1'b0;
        g_lbn     = 1'b0;
        g_data    = '0;
        g_len     = '0;
        g_cs      = '0;
        g_lbn_len = '0;
        for (int unsigned r = 0; r < REQ_N; r++) begin
            if (grant == REQ_W'(r)) begin
                g_early   = req_early_v_i[r];
                g_last    = req_last_i[r];
                g_cancel  = req_cancel_i[r];
                g_lbn     = req_last_block_next_i[r];
                g_data    = req_data_i[r*DATA_W +: DATA_W];
                g_len     = req_len_i[r*LEN_W +: LEN_W];
                g_cs      = req_cs_i[r*UDP_CS_W +: UDP_CS_W];
                g_lbn_len = req_last_block_next_len_i[r*APP_LAST_LEN_W +: APP_LAST_LEN_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            ptr       <= '0;
            pkt_len_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant     <= pick_idx;
                        pkt_len_q <= pick_len;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // An abort from the owner wins over a ready arriving in the same cycle
                    if (g_cancel || !g_early) begin
                        state <= IDLE;
                        ptr   <= inc_wrap(grant);
                    end else if (tx_ready_v_i) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (g_last || g_cancel) begin
                        state <= IDLE;
                        ptr   <= inc_wrap(grant);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        tx_early_v_o             = 1'b0;
        tx_cancel_o              = 1'b0;
        tx_last_o                = 1'b0;
        tx_last_block_next_o     = 1'b0;
        tx_pkt_len_o             = '0;
        tx_cs_o                  = '0;
        tx_data_o                = '0;
        tx_len_o                 = '0;
        tx_last_block_next_len_o = '0;
        req_ready_v_o            = '0;
        case (state)
            WAIT: begin
                tx_early_v_o = 1'b1;
                tx_pkt_len_o = pkt_len_q;
                tx_cancel_o  = g_cancel;
                for (int unsigned r = 0; r < REQ_N; r++) begin
                    req_ready_v_o[r] = (grant == REQ_W'(r)) && tx_ready_v_i && g_early && !g_cancel;
                end
            end
            STREAM: begin
                tx_pkt_len_o             = pkt_len_q;
                tx_data_o                = g_data;
                tx_len_o                 = g_len;
                tx_cs_o                  = g_cs;
                tx_last_o                = g_last;
                tx_cancel_o              = g_cancel;
                tx_last_block_next_o     = g_lbn;
                tx_last_block_next_len_o = g_lbn_len;
            end
            default: ;
        endcase
    end

    assign busy_o  = (state != IDLE);
    assign grant_o = grant;

endmodule
